// File: rtl/ee201_pb_pkg.sv
// Shared types for the push-button event path: event-type codes and arbiter states.
package ee201_pb_pkg;

  typedef enum logic [1:0] {
    EvSingle = 2'b00,
    EvMulti  = 2'b01,
    EvCont   = 2'b10
  } ev_type_e;

  typedef enum logic [0:0] {
    ArbIdle  = 1'b0,
    ArbOffer = 1'b1
  } arb_state_e;

  // Same-cycle priority for one button: single beats multi beats continuous.
  function automatic ev_type_e ev_type_from_pulses(logic scen, logic mcen);
    if (scen) begin
      return EvSingle;
    end else if (mcen) begin
      return EvMulti;
    end
    return EvCont;
  endfunction

  function automatic string ev_type_name(ev_type_e t);
    case (t)
      EvSingle: return "single";
      EvMulti:  return "multi";
      EvCont:   return "continuous";
      default:  return "invalid";
    endcase
  endfunction

endpackage

// File: rtl/ee201_rr_pick.sv
// Combinational round-robin picker: first set bit of valid_i at or after ptr_i, wrapping.
module ee201_rr_pick #(
  parameter int unsigned NBtn = 4,
  parameter int unsigned IdW  = 2
) (
  input  logic [NBtn-1:0] valid_i,
  input  logic [IdW-1:0]  ptr_i,
  output logic            any_o,
  output logic [IdW-1:0]  idx_o
);

  int unsigned cand;

  // Walk offsets high to low so the smallest offset from ptr_i wins.
  always_comb begin
    any_o = |valid_i;
    idx_o = '0;
    cand  = 0;
    for (int off = NBtn - 1; off >= 0; off--) begin
      cand = (int'(ptr_i) + off) % NBtn;
      if (valid_i[cand]) begin
        idx_o = IdW'(cand);
      end
    end
  end

endmodule

// File: rtl/ee201_pb_event_arbiter.sv
// Holds one pending click event per button and serialises them round-robin onto a
// single valid/ready port; dropped events raise a sticky per-button overflow flag.
module ee201_pb_event_arbiter
  import ee201_pb_pkg::*;
#(
  parameter int unsigned NBtn = 4,
  parameter int unsigned IdW  = 2
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NBtn-1:0] scen_i,
  input  logic [NBtn-1:0] mcen_i,
  input  logic [NBtn-1:0] ccen_i,
  input  logic            ev_ready_i,
  input  logic            clr_ovf_i,
  output logic            ev_valid_o,
  output logic [IdW-1:0]  ev_btn_o,
  output logic [1:0]      ev_type_o,
  output logic [NBtn-1:0] ovf_o
);

  arb_state_e      state_q, state_d;
  logic [NBtn-1:0] pend_vld_q, pend_vld_d;
  ev_type_e        pend_type_q [NBtn];
  ev_type_e        pend_type_d [NBtn];
  logic [IdW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [IdW-1:0]  ev_btn_q, ev_btn_d;
  ev_type_e        ev_type_q, ev_type_d;
  logic [NBtn-1:0] ovf_q, ovf_d;
  logic [NBtn-1:0] ovf_set;
  logic [NBtn-1:0] hit;

  logic           any_vld;
  logic [IdW-1:0] sel_idx;
  logic           pick_fire;

  ee201_rr_pick #(
    .NBtn(NBtn),
    .IdW (IdW)
  ) u_rr_pick (
    .valid_i(pend_vld_q),
    .ptr_i  (rr_ptr_q),
    .any_o  (any_vld),
    .idx_o  (sel_idx)
  );

  assign hit       = scen_i | mcen_i | ccen_i;
  assign pick_fire = (state_q == ArbIdle) && any_vld;

  always_comb begin
    state_d   = state_q;
    ev_btn_d  = ev_btn_q;
    ev_type_d = ev_type_q;
    rr_ptr_d  = rr_ptr_q;
    unique case (state_q)
      ArbIdle: begin
        if (any_vld) begin
          state_d   = ArbOffer;
          ev_btn_d  = sel_idx;
          ev_type_d = pend_type_q[sel_idx];
          rr_ptr_d  = (sel_idx == IdW'(NBtn - 1)) ? '0 : sel_idx + IdW'(1);
        end
      end
      ArbOffer: begin
        if (ev_ready_i) begin
          state_d = ArbIdle;
        end
      end
      default: state_d = ArbIdle;
    endcase
  end

  // An entry leaving for the output this cycle frees its slot for a same-cycle pulse.
  always_comb begin
    pend_vld_d  = pend_vld_q;
    pend_type_d = pend_type_q;
    ovf_set     = '0;
    for (int i = 0; i < NBtn; i++) begin
      if (pick_fire && (sel_idx == IdW'(i))) begin
        pend_vld_d[i] = 1'b0;
      end
      if (hit[i]) begin
        if (!pend_vld_q[i] || (pick_fire && (sel_idx == IdW'(i)))) begin
          pend_vld_d[i]  = 1'b1;
          pend_type_d[i] = ev_type_from_pulses(scen_i[i], mcen_i[i]);
        end else begin
          ovf_set[i] = 1'b1;
        end
      end
    end
    ovf_d = (clr_ovf_i ? '0 : ovf_q) | ovf_set;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ArbIdle;
      pend_vld_q <= '0;
      for (int i = 0; i < NBtn; i++) begin
        pend_type_q[i] <= EvSingle;
      end
      rr_ptr_q   <= '0;
      ev_btn_q   <= '0;
      ev_type_q  <= EvSingle;
      ovf_q      <= '0;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_type_q <= pend_type_d;
      rr_ptr_q    <= rr_ptr_d;
      ev_btn_q    <= ev_btn_d;
      ev_type_q   <= ev_type_d;
      ovf_q       <= ovf_d;
    end
  end

  assign ev_valid_o = (state_q == ArbOffer);
  assign ev_btn_o   = ev_btn_q;
  assign ev_type_o  = ev_type_q;
  assign ovf_o      = ovf_q;

endmodule

// File: doc/ee201_pb_event_arbiter.md
Name: ee201_pb_event_arbiter

Overview:
Collects the single-click (SCEN), multi-click (MCEN) and continuous-click (CCEN) pulses from up to N_BTN push-button debouncers. It holds one pending event per button and serialises them, round-robin, onto a single valid/ready event port for one shared consumer (e.g. a display or counter datapath). Lost events are flagged per button. It sits directly downstream of the debouncer bank, in the same clock domain.

Parameters:
N_BTN, 4, number of debounced buttons served (2..8)
ID_W, 2, width of the button index, equal to ceil(log2(N_BTN))

Ports:
CLK  input  1  system clock (100 MHz)
RESET  input  1  asynchronous, active-high reset
SCEN  input  N_BTN  single-click enable pulses, one bit per button, one cycle wide
MCEN  input  N_BTN  multi-click enable pulses, one bit per button
CCEN  input  N_BTN  continuous-click enable pulses, one bit per button
EV_READY  input  1  consumer accepts the current event
CLR_OVF  input  1  clears all OVF bits
EV_VALID  output  1  event presented on EV_BTN/EV_TYPE
EV_BTN  output  ID_W  index of the button that produced the event
EV_TYPE  output  2  event type: 00 = single, 01 = multi, 10 = continuous; 11 is never driven
OVF  output  N_BTN  sticky per-button flag: an event was dropped

Behaviour:
- Reset (asynchronous, RESET=1): EV_VALID=0, EV_BTN=0, EV_TYPE=00, OVF=0, all pending entries invalid, rr_ptr=0, state IDLE.
- Per-button pending entry: one valid bit plus a 2-bit type.
- Capture at edge k when any of SCEN[i], MCEN[i] or CCEN[i] is 1.
- Same-cycle type priority for one button: SCEN > MCEN > CCEN. Only one event is captured; the others are discarded without setting OVF.
- If pending[i] is already valid and is not being selected in the same cycle, the new event is dropped and OVF[i] is set at edge k. The stored entry is unchanged.
- If pending[i] is selected in the same cycle a new pulse arrives, the selected entry moves to the output and the new pulse is captured into pending[i]. No overflow.
- FSM, 2 states:
  - IDLE: EV_VALID=0. If any pending entry is valid, pick the first valid index at or after rr_ptr (wrapping modulo N_BTN). At the next edge: load EV_BTN/EV_TYPE, set EV_VALID=1, clear that pending entry, set rr_ptr = (index+1) mod N_BTN, go to OFFER.
  - OFFER: EV_VALID=1; EV_BTN and EV_TYPE held stable. When EV_READY=1 at an edge (handshake), set EV_VALID=0 and go to IDLE. Otherwise stay.
- Latency: a pulse at edge k into an empty, IDLE arbiter gives EV_VALID=1 after edge k+1.
- Throughput: at most one event per 2 cycles.
- EV_READY is ignored in IDLE.
- OVF bits stay set until CLR_OVF=1 at an edge. If an overflow and CLR_OVF occur in the same cycle, set wins for that bit.
- RESET asserted mid-OFFER drops the offered event and all pending entries immediately.
- rr_ptr arithmetic wraps modulo N_BTN, including when N_BTN is not a power of two.

Decomposition:
- Shared package (ee201_pb_pkg):
  - EV_TYPE encodings EV_SINGLE=2'b00, EV_MULTI=2'b01, EV_CONT=2'b10.
  - Arbiter state encodings ARB_IDLE, ARB_OFFER.
  - Reused by the debouncer bench for string decoding.
- One sub-module, ee201_rr_pick: combinational round-robin picker.
  - Inputs: pending-valid vector, rr_ptr.
  - Outputs: any_valid, selected index.
  - Instantiated once.

Test Plan:
1. Reset, then SCEN[2] pulse at cycle 5 with EV_READY=1 -> EV_VALID=1 during cycle 6 only, EV_BTN=2, EV_TYPE=00; OVF=0.
2. SCEN[0], MCEN[1] and CCEN[3] in the same cycle, EV_READY held 1 -> events emitted in order btn0/00, btn1/01, btn3/10, spaced 2 cycles apart; rr_ptr ends at 0.
3. EV_READY=0, MCEN[1] pulse, then SCEN[1] 3 cycles later -> first pulse is moved to the output, second is captured into pending (no OVF). A third pulse, CCEN[1], 2 cycles later -> OVF[1]=1. Then EV_READY=1 -> btn1/01 then btn1/00 are delivered; the CCEN event is lost.
4. SCEN[2] and CCEN[2] in the same cycle -> a single event btn2/00 is emitted; OVF[2] stays 0.
5. CLR_OVF=1 in the same cycle as a new overflow on btn3 -> OVF[3] stays 1; the other OVF bits clear to 0.
6. RESET pulsed while in OFFER with 2 entries pending -> EV_VALID=0 asynchronously; after release no events are emitted; EV_BTN=0, EV_TYPE=00.
